// File: rtl/robot_fsm_follower.sv
// Two-state wall/line follower: q=1 clear path, q=0 obstacle or wall contact.
// Optional feature macro ROBOT_OUT_REG_EN registers the a/r motor commands (one-cycle lag).
module robot_fsm_follower #(
  parameter logic INIT_STATE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic preset,
  input  logic h,
  input  logic l,
  output logic a,
  output logic r,
  output logic q,
  output logic nq
);

  typedef enum logic {
    ST_CONTACT = 1'b0,
    ST_CLEAR   = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  // The path is clear only when neither sensor sees anything; the current state does not matter.
  always_comb begin
    state_d = ST_CONTACT;
    if (!h && !l) begin
      state_d = ST_CLEAR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset or negedge preset) begin
    if (!reset) begin
      state_q <= state_e'(INIT_STATE);
    end else if (!preset) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  assign q  = state_q;
  assign nq = ~state_q;

`ifdef ROBOT_OUT_REG_EN
  logic a_q;
  logic r_q;

  // Motor commands are cleared by reset only; preset leaves them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      a_q <= ~h;
      r_q <= h;
    end
  end

  assign a = a_q;
  assign r = r_q;
`else
  // Gating with reset keeps the motors stopped while reset is held.
  assign a = reset & ~h;
  assign r = reset & h;
`endif

endmodule

// File: tb/tb_robot_fsm_follower.sv
// Directed testbench for robot_fsm_follower; also models the ROBOT_OUT_REG_EN variant.
module tb_robot_fsm_follower;

  logic clk = 1'b0;
  logic reset;
  logic preset;
  logic h;
  logic l;
  logic a;
  logic r;
  logic q;
  logic nq;

  int checks = 0;
  int errors = 0;

  // Model of the registered motor outputs (used only when ROBOT_OUT_REG_EN is defined).
  logic reg_a = 1'b0;
  logic reg_r = 1'b0;

  robot_fsm_follower dut (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .h      (h),
    .l      (l),
    .a      (a),
    .r      (r),
    .q      (q),
    .nq     (nq)
  );

  always #5 clk = ~clk;

  function automatic logic exp_a();
`ifdef ROBOT_OUT_REG_EN
    return reg_a;
`else
    return reset & ~h;
`endif
  endfunction

  function automatic logic exp_r();
`ifdef ROBOT_OUT_REG_EN
    return reg_r;
`else
    return reset & h;
`endif
  endfunction

  task automatic apply(input logic hv, input logic lv);
    h = hv;
    l = lv;
    #1;
  endtask

  task automatic edge_clk();
    @(posedge clk);
    if (!reset) begin
      reg_a = 1'b0;
      reg_r = 1'b0;
    end else begin
      reg_a = ~h;
      reg_r = h;
    end
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    preset = 1'b1;
    h = 1'b0;
    l = 1'b0;
    reg_a = 1'b0;
    reg_r = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL reset_q: got %b exp 0", q); end
    checks++; if (nq !== 1'b1) begin errors++; $display("FAIL reset_nq: got %b exp 1", nq); end
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_a: got %b exp 0", a); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL reset_r: got %b exp 0", r); end
    apply(1'b1, 1'b0);
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL reset_r_h1: got %b exp 0", r); end
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL reset_a_h1: got %b exp 0", a); end
    h = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_release();
    apply(1'b0, 1'b0);
    checks++; if (a !== exp_a()) begin errors++; $display("FAIL release_a_pre: got %b exp %b", a, exp_a()); end
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL release_q: got %b exp 1", q); end
    checks++; if (nq !== 1'b0) begin errors++; $display("FAIL release_nq: got %b exp 0", nq); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL release_a: got %b exp 1", a); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL release_r: got %b exp 0", r); end
    @(negedge clk);
    apply(1'b0, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL release_hold_q: got %b exp 1", q); end
  endtask

  task automatic test_obstacle();
    @(negedge clk);
    apply(1'b1, 1'b0);
    checks++; if (r !== exp_r()) begin errors++; $display("FAIL obstacle_r_pre: got %b exp %b", r, exp_r()); end
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL obstacle_q: got %b exp 0", q); end
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL obstacle_a: got %b exp 0", a); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL obstacle_r: got %b exp 1", r); end
    @(negedge clk);
    apply(1'b0, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL obstacle_clear_q: got %b exp 1", q); end
    @(negedge clk);
    apply(1'b1, 1'b1);
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL obstacle_both_q: got %b exp 0", q); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL obstacle_both_r: got %b exp 1", r); end
  endtask

  task automatic test_left_contact();
    @(negedge clk);
    apply(1'b0, 1'b1);
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL left_q: got %b exp 0", q); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL left_a: got %b exp 1", a); end
    checks++; if (r !== 1'b0) begin errors++; $display("FAIL left_r: got %b exp 0", r); end
    @(negedge clk);
    apply(1'b1, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL left_then_head_q: got %b exp 0", q); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL left_then_head_r: got %b exp 1", r); end
  endtask

  task automatic test_sequence();
    logic [1:0] hl_vec [11] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00,
                                2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
    logic       q_vec  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      apply(hl_vec[i][1], hl_vec[i][0]);
      checks++;
      if (a !== exp_a() || r !== exp_r()) begin
        errors++;
        $display("FAIL seq_pre_ar[%0d]: got a=%b r=%b exp a=%b r=%b", i, a, r, exp_a(), exp_r());
      end
      edge_clk();
      checks++;
      if (q !== q_vec[i] || nq !== ~q_vec[i]) begin
        errors++;
        $display("FAIL seq_q[%0d]: got q=%b nq=%b exp q=%b nq=%b", i, q, nq, q_vec[i], ~q_vec[i]);
      end
      checks++;
      if (a !== ~hl_vec[i][1] || r !== hl_vec[i][1]) begin
        errors++;
        $display("FAIL seq_ar[%0d]: got a=%b r=%b exp a=%b r=%b", i, a, r, ~hl_vec[i][1], hl_vec[i][1]);
      end
    end
  endtask

  task automatic test_async();
    // q is 0 here; assert preset mid-cycle while the head sensor is blocked.
    @(negedge clk);
    apply(1'b1, 1'b1);
    preset = 1'b0;
    #1;
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL preset_q: got %b exp 1", q); end
    checks++; if (nq !== 1'b0) begin errors++; $display("FAIL preset_nq: got %b exp 0", nq); end
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL preset_hold_q: got %b exp 1", q); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL preset_r: got %b exp 1", r); end
    @(negedge clk);
    preset = 1'b1;
    apply(1'b1, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL preset_release_q: got %b exp 0", q); end
    @(negedge clk);
    apply(1'b0, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL pre_both_q: got %b exp 1", q); end
    @(negedge clk);
    reset  = 1'b0;
    preset = 1'b0;
    reg_a  = 1'b0;
    reg_r  = 1'b0;
    #1;
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL both_low_q: got %b exp 0", q); end
    checks++; if (a !== 1'b0 || r !== 1'b0) begin errors++; $display("FAIL both_low_ar: got a=%b r=%b exp 0 0", a, r); end
    edge_clk();
    checks++; if (q !== 1'b0) begin errors++; $display("FAIL both_low_edge_q: got %b exp 0", q); end
    @(negedge clk);
    preset = 1'b1;
    reset  = 1'b1;
    apply(1'b0, 1'b0);
    edge_clk();
    checks++; if (q !== 1'b1) begin errors++; $display("FAIL both_release_q: got %b exp 1", q); end
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL both_release_a: got %b exp 1", a); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_obstacle();
    test_left_contact();
    test_sequence();
    test_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
